// File: rtl/control_fsm.sv
// control_fsm: multicycle main control unit for the RV64 subset datapath
// (ADD, SUB, ADDI, LD, SD, BEQ, BNE, LUI); drives imm_sel to the sign-extend stage.
`default_nettype none

module control_fsm #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        ir_load,
  output logic        pc_write,
  output logic        pc_src,
  output logic        mem_addr_sel,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic [3:0]  imm_sel,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    WB_ALU   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    WB_MEM   = 4'd7,
    MEM_WR   = 4'd8,
    BRANCH   = 4'd9,
    LUI_WB   = 4'd10,
    HALT     = 4'd11
  } state_e;

  localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_r, is_sub, is_addi, is_ld, is_sd, is_beq, is_bne, is_lui;
  logic [3:0] class_imm;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  assign is_r    = (opcode == 7'b0110011) && (funct3 == 3'b000) &&
                   ((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
  assign is_sub  = is_r && funct7[5];
  assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_ld   = (opcode == 7'b0000011) && (funct3 == 3'b011);
  assign is_sd   = (opcode == 7'b0100011) && (funct3 == 3'b011);
  assign is_beq  = (opcode == 7'b1100011) && (funct3 == 3'b000);
  assign is_bne  = (opcode == 7'b1100011) && (funct3 == 3'b001);
  assign is_lui  = (opcode == 7'b0110111);

  // Immediate format is a property of the instruction, held for its whole lifetime.
  always_comb begin
    class_imm = 4'd0;
    if (is_addi || is_ld) class_imm = 4'd1;
    else if (is_beq || is_bne) class_imm = 4'd2;
    else if (is_lui) class_imm = 4'd3;
    else if (is_sd) class_imm = 4'd4;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      FETCH, MEM_RD: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 4'd0;
          state_d = (state_q == FETCH) ? DECODE : WB_MEM;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DECODE: begin
        if (is_r) state_d = EXEC_R;
        else if (is_addi) state_d = EXEC_I;
        else if (is_ld || is_sd) state_d = MEM_ADDR;
        else if (is_beq || is_bne) state_d = BRANCH;
        else if (is_lui) state_d = LUI_WB;
        else state_d = HALT;
      end
      EXEC_R, EXEC_I: state_d = WB_ALU;
      MEM_ADDR:       state_d = is_ld ? MEM_RD : MEM_WR;
      WB_ALU, WB_MEM, MEM_WR, BRANCH, LUI_WB: state_d = FETCH;
      HALT:           state_d = HALT;
      default:        state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low while reset is high so no strobe survives reset rising.
  always_comb begin
    ir_load      = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    mem_addr_sel = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = 2'd0;
    imm_sel      = 4'd0;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    illegal      = 1'b0;
    state_dbg    = 4'd0;
    if (!reset) begin
      state_dbg = state_q;
      if (state_q != FETCH && state_q != HALT) imm_sel = class_imm;
      case (state_q)
        FETCH: begin
          mem_rd = 1'b1;
          if (cnt_q == CNT_LAST) begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
          end
        end
        EXEC_R:   alu_op = is_sub ? 2'd1 : 2'd0;
        EXEC_I:   alu_src_b = 1'b1;
        WB_ALU:   reg_write = 1'b1;
        MEM_ADDR: alu_src_b = 1'b1;
        MEM_RD: begin
          mem_rd       = 1'b1;
          mem_addr_sel = 1'b1;
        end
        WB_MEM: begin
          reg_write = 1'b1;
          wb_sel    = 2'd1;
        end
        MEM_WR: begin
          mem_wr       = 1'b1;
          mem_addr_sel = 1'b1;
        end
        BRANCH: begin
          alu_op   = 2'd1;
          pc_src   = 1'b1;
          pc_write = (is_beq & zero) | (is_bne & ~zero);
        end
        LUI_WB: begin
          reg_write = 1'b1;
          wb_sel    = 2'd2;
        end
        HALT:    illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed self-checking bench for control_fsm with MEM_LATENCY = 2.
`default_nettype none

module tb_control_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = 32'd0;
  logic        zero = 1'b0;
  logic        ir_load, pc_write, pc_src, mem_addr_sel, mem_rd, mem_wr, alu_src_b;
  logic [1:0]  alu_op, wb_sel;
  logic [3:0]  imm_sel, state_dbg;
  logic        reg_write, illegal;

  control_fsm #(.MEM_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero),
    .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src),
    .mem_addr_sel(mem_addr_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_sel(imm_sel),
    .reg_write(reg_write), .wb_sel(wb_sel), .illegal(illegal), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  logic [20:0] all_out;
  assign all_out = {ir_load, pc_write, pc_src, mem_addr_sel, mem_rd, mem_wr, alu_src_b,
                    alu_op, imm_sel, reg_write, wb_sel, illegal, state_dbg};

  int n_pass = 0;
  int n_total = 0;

  logic       a_ir[1:32], a_pcw[1:32], a_pcs[1:32], a_mas[1:32], a_mrd[1:32];
  logic       a_mwr[1:32], a_asb[1:32], a_rw[1:32], a_ill[1:32];
  logic [1:0] a_op[1:32], a_wb[1:32];
  logic [3:0] a_imm[1:32], a_st[1:32];

  // Record outputs for cycles 1..n; cycle 1 is the first cycle after reset release.
  task automatic capture(input int n);
    for (int c = 1; c <= n; c++) begin
      a_ir[c] = ir_load;   a_pcw[c] = pc_write; a_pcs[c] = pc_src;
      a_mas[c] = mem_addr_sel; a_mrd[c] = mem_rd; a_mwr[c] = mem_wr;
      a_asb[c] = alu_src_b; a_rw[c] = reg_write; a_ill[c] = illegal;
      a_op[c] = alu_op; a_wb[c] = wb_sel; a_imm[c] = imm_sel; a_st[c] = state_dbg;
      if (c < n) begin
        @(negedge clk);
        #1;
      end
    end
  endtask

  task automatic start(input logic [31:0] ins, input logic z);
    reset = 1'b1;
    instr = ins;
    zero  = z;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    instr = 32'h00500093;
    zero  = 1'b1;
    @(negedge clk);
    #1;
    n_total++;
    if (all_out !== 21'd0) $display("FAIL reset_outputs: got %h want 0", all_out);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if ({state_dbg, mem_rd, mem_addr_sel, ir_load} !== {4'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_fetch: state %0d rd %b sel %b ir %b want 0 1 0 0",
               state_dbg, mem_rd, mem_addr_sel, ir_load);
    else n_pass++;
  endtask

  task automatic test_addi_back_to_back;
    start(32'h00500093, 1'b0);
    capture(9);
    n_total++;
    if ({a_ir[1], a_ir[2], a_pcw[2], a_pcs[2]} !== 4'b0110)
      $display("FAIL addi_fetch: ir %b%b pcw %b pcs %b want 0 1 1 0", a_ir[1], a_ir[2], a_pcw[2], a_pcs[2]);
    else n_pass++;
    for (int c = 3; c <= 5; c++) begin
      n_total++;
      if (a_imm[c] !== 4'd1) $display("FAIL addi_imm_sel c%0d: got %0d want 1", c, a_imm[c]);
      else n_pass++;
    end
    n_total++;
    if ({a_st[4], a_asb[4], a_op[4]} !== {4'd3, 1'b1, 2'd0})
      $display("FAIL addi_exec: state %0d asb %b op %0d want 3 1 0", a_st[4], a_asb[4], a_op[4]);
    else n_pass++;
    for (int c = 1; c <= 9; c++) begin
      n_total++;
      if (a_rw[c] !== (c == 5)) $display("FAIL addi_reg_write c%0d: got %b want %b", c, a_rw[c], c == 5);
      else n_pass++;
    end
    n_total++;
    if (a_wb[5] !== 2'd0) $display("FAIL addi_wb_sel: got %0d want 0", a_wb[5]);
    else n_pass++;
    n_total++;
    if ({a_st[6], a_ir[7], a_st[8]} !== {4'd0, 1'b1, 4'd1})
      $display("FAIL addi_back_to_back: st6 %0d ir7 %b st8 %0d want 0 1 1", a_st[6], a_ir[7], a_st[8]);
    else n_pass++;
  endtask

  task automatic test_sd;
    int wr_cnt;
    start(32'h00113423, 1'b0);
    capture(8);
    n_total++;
    if ({a_st[4], a_imm[4], a_asb[4]} !== {4'd5, 4'd4, 1'b1})
      $display("FAIL sd_mem_addr: state %0d imm %0d asb %b want 5 4 1", a_st[4], a_imm[4], a_asb[4]);
    else n_pass++;
    wr_cnt = 0;
    for (int c = 1; c <= 8; c++) wr_cnt += int'(a_mwr[c]);
    n_total++;
    if (wr_cnt != 1 || a_mwr[5] !== 1'b1 || a_mas[5] !== 1'b1)
      $display("FAIL sd_mem_wr: count %0d c5 %b sel %b want 1 1 1", wr_cnt, a_mwr[5], a_mas[5]);
    else n_pass++;
    for (int c = 1; c <= 8; c++) begin
      n_total++;
      if (a_rw[c] !== 1'b0) $display("FAIL sd_reg_write c%0d: got %b want 0", c, a_rw[c]);
      else n_pass++;
    end
    n_total++;
    if (a_st[6] !== 4'd0) $display("FAIL sd_return: got %0d want 0", a_st[6]);
    else n_pass++;
  endtask

  task automatic test_branch(input logic [31:0] ins, input logic z, input logic exp_pcw, input string nm);
    start(ins, z);
    capture(6);
    n_total++;
    if ({a_st[4], a_pcw[4], a_pcs[4], a_imm[4], a_op[4], a_asb[4]} !== {4'd9, exp_pcw, 1'b1, 4'd2, 2'd1, 1'b0})
      $display("FAIL %s: state %0d pcw %b pcs %b imm %0d op %0d asb %b want 9 %b 1 2 1 0",
               nm, a_st[4], a_pcw[4], a_pcs[4], a_imm[4], a_op[4], a_asb[4], exp_pcw);
    else n_pass++;
    n_total++;
    if ({a_st[5], a_pcw[3], a_pcw[5]} !== {4'd0, 1'b0, 1'b0})
      $display("FAIL %s_around: st5 %0d pcw3 %b pcw5 %b want 0 0 0", nm, a_st[5], a_pcw[3], a_pcw[5]);
    else n_pass++;
  endtask

  task automatic test_ld_and_reset;
    start(32'h00013183, 1'b0);
    capture(9);
    n_total++;
    if ({a_st[5], a_st[6], a_mrd[5], a_mrd[6], a_mas[5], a_mas[6]} !== {4'd6, 4'd6, 4'b1111})
      $display("FAIL ld_mem_rd: st %0d %0d rd %b%b sel %b%b want 6 6 11 11",
               a_st[5], a_st[6], a_mrd[5], a_mrd[6], a_mas[5], a_mas[6]);
    else n_pass++;
    n_total++;
    if ({a_rw[6], a_rw[7], a_wb[7], a_st[8]} !== {1'b0, 1'b1, 2'd1, 4'd0})
      $display("FAIL ld_wb: rw6 %b rw7 %b wb %0d st8 %0d want 0 1 1 0", a_rw[6], a_rw[7], a_wb[7], a_st[8]);
    else n_pass++;
    // Second run: abandon the load in its first MEM_RD cycle.
    start(32'h00013183, 1'b0);
    capture(5);
    n_total++;
    if (a_st[5] !== 4'd6) $display("FAIL ld_reach_mem_rd: got %0d want 6", a_st[5]);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if (all_out !== 21'd0) $display("FAIL ld_reset_immediate: got %h want 0", all_out);
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if (all_out !== 21'd0) $display("FAIL ld_reset_held: got %h want 0", all_out);
    else n_pass++;
    reset = 1'b0;
    #1;
    capture(3);
    n_total++;
    if ({a_st[1], a_ir[1], a_ir[2], a_st[3]} !== {4'd0, 1'b0, 1'b1, 4'd1})
      $display("FAIL ld_restart: st1 %0d ir1 %b ir2 %b st3 %0d want 0 0 1 1", a_st[1], a_ir[1], a_ir[2], a_st[3]);
    else n_pass++;
    n_total++;
    if ({a_rw[1], a_rw[2], a_rw[3]} !== 3'b000)
      $display("FAIL ld_no_reg_write: got %b%b%b want 000", a_rw[1], a_rw[2], a_rw[3]);
    else n_pass++;
  endtask

  task automatic test_illegal;
    start(32'h00000000, 1'b0);
    capture(20);
    n_total++;
    if ({a_st[3], a_ill[3]} !== {4'd1, 1'b0})
      $display("FAIL illegal_decode: state %0d ill %b want 1 0", a_st[3], a_ill[3]);
    else n_pass++;
    for (int c = 4; c <= 20; c++) begin
      n_total++;
      if ({a_ill[c], a_st[c], a_ir[c], a_pcw[c], a_mrd[c], a_mwr[c], a_rw[c]} !== {1'b1, 4'd11, 5'b00000})
        $display("FAIL illegal_halt c%0d: ill %b state %0d strobes %b%b%b%b%b want 1 11 00000",
                 c, a_ill[c], a_st[c], a_ir[c], a_pcw[c], a_mrd[c], a_mwr[c], a_rw[c]);
      else n_pass++;
    end
    reset = 1'b1;
    #1;
    n_total++;
    if (all_out !== 21'd0) $display("FAIL illegal_reset: got %h want 0", all_out);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_total++;
    if ({illegal, state_dbg} !== {1'b0, 4'd0})
      $display("FAIL illegal_cleared: ill %b state %0d want 0 0", illegal, state_dbg);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_addi_back_to_back();
    test_sd();
    test_branch(32'h00208463, 1'b1, 1'b1, "beq_taken");
    test_branch(32'h00208463, 1'b0, 1'b0, "beq_not_taken");
    test_branch(32'h00209463, 1'b1, 1'b0, "bne_not_taken");
    test_branch(32'h00209463, 1'b0, 1'b1, "bne_taken");
    test_ld_and_reset();
    test_illegal();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
